// File: rtl/s2p_pkg.sv
// Shared types for the lane arbiter: FSM states, default byte type and the
// lane-index width helper.
package s2p_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;

    // Index width for a lane count; never narrower than one bit.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s2p_lane_slot.sv
// One-deep holding slot for a single deserializer lane. A byte is accepted
// when the slot is empty or is being drained in the same cycle; otherwise a
// capture request is dropped and reported as a one-cycle overflow pulse.
import s2p_pkg::*;

module s2p_lane_slot #(
    parameter int DATA_W = BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              drain,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data,
    output logic              full,
    output logic              ovf
);

    logic load;

    assign load = capture && (!full || drain);

    // Full flag and overflow pulse; reset empties the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            ovf <= capture && full && !drain;
            if (load)
                full <= 1'b1;
            else if (drain)
                full <= 1'b0;
        end
    end

    // Byte storage; contents are only meaningful while full is set.
    always_ff @(posedge clk) begin
        if (load)
            data <= data_in;
    end

endmodule

// File: rtl/s2p_lane_arbiter.sv
// Merges bytes from NUM_LANES deserializer lanes into one valid/ready stream
// through per-lane holding slots, a round-robin scheduler and a registered
// output stage. Optional feature: define S2P_ARB_OVF_CNT_EN to add one
// saturating overflow counter per lane on the ovf_cnt port.
import s2p_pkg::*;

module s2p_lane_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int OVF_CNT_W = 8,
    localparam int LANE_W   = lane_w(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_LANES-1:0]        lane_valid,
    input  logic [NUM_LANES*DATA_W-1:0] lane_data,
    output logic                        dout_valid,
    output logic [DATA_W-1:0]           dout_data,
    output logic [LANE_W-1:0]           dout_lane,
    input  logic                        dout_ready,
    output logic [NUM_LANES-1:0]        lane_ovf,
    output logic                        busy
`ifdef S2P_ARB_OVF_CNT_EN
    ,
    output logic [NUM_LANES*OVF_CNT_W-1:0] ovf_cnt
`endif
);

    state_t                state, state_nxt;
    logic [NUM_LANES-1:0]  capture;
    logic [NUM_LANES-1:0]  drain;
    logic [NUM_LANES-1:0]  slot_full;
    logic [DATA_W-1:0]     slot_data [NUM_LANES];
    logic [LANE_W-1:0]     rr_ptr;
    logic [LANE_W-1:0]     grant_idx;
    logic                  grant_vld;
    logic                  load_ok;

    // Output register can take a new byte when empty or being consumed.
    assign load_ok = !dout_valid || dout_ready;
    assign capture = (state == S_RUN) ? lane_valid : '0;
    assign busy    = (state != S_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state; DRAIN returns to RUN on en even before it has emptied.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)
                    state_nxt = S_RUN;
                else if ((slot_full == '0) && !dout_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round-robin search: first full slot at or after rr_ptr, with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!grant_vld &&
                slot_full[LANE_W'((int'(rr_ptr) + i) % NUM_LANES)]) begin
                grant_vld = 1'b1;
                grant_idx = LANE_W'((int'(rr_ptr) + i) % NUM_LANES);
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign drain[k] = grant_vld && load_ok && (grant_idx == LANE_W'(k));

        s2p_lane_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .capture (capture[k]),
            .drain   (drain[k]),
            .data_in (lane_data[k*DATA_W +: DATA_W]),
            .data    (slot_data[k]),
            .full    (slot_full[k]),
            .ovf     (lane_ovf[k])
        );
    end

    // Output stage: load a granted slot, empty out, or hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_lane  <= '0;
            rr_ptr     <= '0;
        end else if (load_ok && grant_vld) begin
            dout_valid <= 1'b1;
            dout_data  <= slot_data[grant_idx];
            dout_lane  <= grant_idx;
            rr_ptr     <= (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                                : grant_idx + 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef S2P_ARB_OVF_CNT_EN
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
        logic [OVF_CNT_W-1:0] cnt;

        // Saturating count of dropped bytes; only reset clears it.
        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt <= '0;
            else if (lane_ovf[k] && (cnt != '1))
                cnt <= cnt + 1'b1;
        end

        assign ovf_cnt[k*OVF_CNT_W +: OVF_CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_s2p_lane_arbiter.sv
// Self-checking bench for s2p_lane_arbiter: expected bytes are queued when
// lanes are strobed and compared on every output handshake.
module tb_s2p_lane_arbiter;

    localparam int NUM_LANES = 4;
    localparam int DATA_W    = 8;
    localparam int OVF_CNT_W = 8;
    localparam int LANE_W    = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        en;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES*DATA_W-1:0] lane_data;
    logic                        dout_valid;
    logic [DATA_W-1:0]           dout_data;
    logic [LANE_W-1:0]           dout_lane;
    logic                        dout_ready;
    logic [NUM_LANES-1:0]        lane_ovf;
    logic                        busy;
`ifdef S2P_ARB_OVF_CNT_EN
    logic [NUM_LANES*OVF_CNT_W-1:0] ovf_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    s2p_lane_arbiter #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .OVF_CNT_W (OVF_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_lane  (dout_lane),
        .dout_ready (dout_ready),
        .lane_ovf   (lane_ovf),
        .busy       (busy)
`ifdef S2P_ARB_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [7:0] val);
        lane_data[k*DATA_W +: DATA_W] = val;
    endtask

    task automatic push(input int lane, input int data);
        sb_q.push_back(32'((lane << 8) | data));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_data"},  32'(dout_data),  32'd0);
        check({tag, "_lane"},  32'(dout_lane),  32'd0);
        check({tag, "_ovf"},   32'(lane_ovf),   32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard: every accepted output byte must match the head of the queue.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (rst_n && dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_spurious", 32'(sb_q.size()), 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check("dout", {22'd0, dout_lane, dout_data}, exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        lane_valid = '0;
        lane_data  = '0;
        dout_ready = 1'b1;

        // Test 1: single byte, latency and single-cycle valid
        step();
        rst_n = 1'b1;
        check_reset_vals("rst0");
        step();
        check("t1_busy", 32'(busy), 32'd1);
        set_lane(2, 8'hA5);
        lane_valid = 4'b0100;
        push(2, 8'hA5);
        step();
        lane_valid = '0;
        check("t1_lat1", 32'(dout_valid), 32'd0);
        step();
        check("t1_lat2", 32'(dout_valid), 32'd1);
        step();
        check("t1_single", 32'(dout_valid), 32'd0);
        check("t1_sb", 32'(sb_q.size()), 32'd0);

        // Test 2: all lanes at once from rr_ptr=0 -> lanes 0,1,2,3
        do_reset();
        step();
        for (int k = 0; k < NUM_LANES; k++) begin
            set_lane(k, 8'(8'h10 + k));
            push(k, 8'h10 + k);
        end
        lane_valid = 4'b1111;
        step();
        lane_valid = '0;
        repeat (6) step();
        check("t2_sb", 32'(sb_q.size()), 32'd0);

        // Test 3: stalled output, lane 1 overflows on its third byte
        dout_ready = 1'b0;
        set_lane(1, 8'h11);
        lane_valid = 4'b0010;
        push(1, 8'h11);
        step();
        set_lane(1, 8'h33);
        push(1, 8'h33);
        step();
        set_lane(1, 8'h22);
        step();
        lane_valid = '0;
        check("t3_ovf", 32'(lane_ovf), 32'h2);
        check("t3_hold", 32'(dout_data), 32'h11);
        step();
        check("t3_ovf_once", 32'(lane_ovf), 32'h0);
        check("t3_hold2", {22'd0, dout_lane, dout_data}, 32'h111);
`ifdef S2P_ARB_OVF_CNT_EN
        check("t3_cnt", 32'(ovf_cnt[15:8]), 32'd1);
`endif
        dout_ready = 1'b1;
        repeat (4) step();
        check("t3_sb", 32'(sb_q.size()), 32'd0);

        // Test 4: lane 0 strobe coincident with its grant
        set_lane(0, 8'h40);
        lane_valid = 4'b0001;
        push(0, 8'h40);
        step();
        set_lane(0, 8'h41);
        push(0, 8'h41);
        step();
        lane_valid = '0;
        check("t4_no_ovf", 32'(lane_ovf), 32'h0);
        repeat (4) step();
        check("t4_sb", 32'(sb_q.size()), 32'd0);

        // Test 5: drain with all slots full; rr_ptr is 1 after the lane-0 grant
        dout_ready = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) set_lane(k, 8'(8'h50 + k));
        push(1, 8'h51);
        push(2, 8'h52);
        push(3, 8'h53);
        push(0, 8'h50);
        lane_valid = 4'b1111;
        step();
        lane_valid = '0;
        en = 1'b0;
        step();
        for (int k = 0; k < NUM_LANES; k++) set_lane(k, 8'hEE);
        lane_valid = 4'b1111;
        step();
        lane_valid = '0;
        check("t5_drain_noovf", 32'(lane_ovf), 32'h0);
        check("t5_busy", 32'(busy), 32'd1);
        dout_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) step();
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_sb", 32'(sb_q.size()), 32'd0);
        lane_valid = 4'b1111;
        step();
        lane_valid = '0;
        check("t5_idle_noovf", 32'(lane_ovf), 32'h0);
        step();
        check("t5_idle_nout", 32'(dout_valid), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Test 6: reset with full slots and a held output byte
        en = 1'b1;
        step();
        dout_ready = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) set_lane(k, 8'(8'h60 + k));
        lane_valid = 4'b1111;
        step();
        lane_valid = '0;
        step();
        check("t6_pre", 32'(dout_valid), 32'd1);
        do_reset();
        check_reset_vals("t6_rst");
        dout_ready = 1'b1;
        repeat (5) step();
        check("t6_empty", 32'(dout_valid), 32'd0);
        check("t6_sb", 32'(sb_q.size()), 32'd0);

`ifdef S2P_ARB_OVF_CNT_EN
        // Counter saturation: 300 drops on lane 3
        dout_ready = 1'b0;
        set_lane(3, 8'h77);
        lane_valid = 4'b1000;
        repeat (302) step();
        lane_valid = '0;
        step();
        check("cnt_sat", 32'(ovf_cnt[31:24]), 32'd255);
        check("cnt_l0", 32'(ovf_cnt[7:0]), 32'd0);
        do_reset();
        check("cnt_rst", 32'(ovf_cnt), 32'd0);
        dout_ready = 1'b1;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
